// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic       REQ_IF  = 1'b0;
    localparam logic       REQ_DM  = 1'b1;
    localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the arbiter (master) and the memory model (slave).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating counter of DM grants won while a fetch waits; clear beats increment.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != MAX_V)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign sat_o = (cnt_q == MAX_V);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and MEM-stage data access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          stall_if,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [2:0]    dm_funct3,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_dm,
    mem_port_arbiter_if.master mem
);
    state_t        state_q, state_d;
    logic          grant_if, grant_dm, gnt_id, wait_sat;
    logic          mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [2:0]    mem_funct3_q;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          if_valid_q, dm_valid_q;

    // DM has priority unless the fetch has already lost MAX_IF_WAIT arbitrations in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == ST_IDLE) begin
            if (if_req && (!dm_req || wait_sat)) grant_if = 1'b1;
            else if (dm_req)                     grant_dm = 1'b1;
        end
        gnt_id = grant_dm ? REQ_DM : REQ_IF;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_if)      state_d = ST_BUSY_IF;
                        else if (grant_dm) state_d = ST_BUSY_DM;
            ST_BUSY_IF,
            ST_BUSY_DM: if (mem.mem_ready) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    arb_starve_ctr #(.W(4), .MAX(MAX_IF_WAIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (grant_dm & if_req),
        .clr_i (grant_if | ~if_req),
        .sat_o (wait_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (grant_if || grant_dm) begin
                mem_req_q    <= 1'b1;
                mem_we_q     <= (gnt_id == REQ_DM) && dm_we;
                mem_addr_q   <= (gnt_id == REQ_DM) ? dm_addr : if_addr;
                mem_wdata_q  <= (gnt_id == REQ_DM) ? dm_wdata : '0;
                mem_funct3_q <= (gnt_id == REQ_DM) ? dm_funct3 : F3_WORD;
            end
            // Valid regs are set on completion so they are high exactly during RESP.
            if (state_q == ST_BUSY_IF && mem.mem_ready) begin
                mem_req_q  <= 1'b0;
                if_rdata_q <= mem.mem_rdata;
                if_valid_q <= 1'b1;
            end
            if (state_q == ST_BUSY_DM && mem.mem_ready) begin
                mem_req_q  <= 1'b0;
                if (!mem_we_q) dm_rdata_q <= mem.mem_rdata;
                dm_valid_q <= 1'b1;
            end
        end
    end

    assign mem.mem_req    = mem_req_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_funct3 = mem_funct3_q;

    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_valid = dm_valid_q;
    assign stall_if = if_req & ~if_valid_q;
    assign stall_dm = dm_req & ~dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [2:0]  dm_funct3;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_valid, dm_valid, stall_if, stall_dm;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    bit spur   = 1'b0;

    typedef struct { bit dm; logic [31:0] data; } exp_t;
    exp_t sbq[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_IF_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall_dm(stall_dm), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h14:  return 32'h00A0_0113;
            32'h100: return 32'h1234_5678;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    // Memory model: mem_ready on the lat-th cycle of mem_req; stores return junk data.
    initial begin
        int cnt = 0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                cnt = 0;
                mem_bus.mem_ready = 1'b0;
            end else if (mem_bus.mem_req) begin
                cnt++;
                mem_bus.mem_ready = (cnt == lat);
                mem_bus.mem_rdata = mem_bus.mem_we ? 32'hBAD0_BAD0 : mem_data(mem_bus.mem_addr);
            end else begin
                cnt = 0;
                mem_bus.mem_ready = spur;
                mem_bus.mem_rdata = 32'hFFFF_0000;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (if_valid || dm_valid)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", 32'({if_valid, dm_valid}), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_both_valid", 32'(if_valid & dm_valid), 32'd0);
                chk("sb_dm_id", 32'(dm_valid), 32'(e.dm));
                chk("sb_rdata", dm_valid ? dm_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic push(input bit dm, input logic [31:0] data);
        exp_t e;
        e.dm = dm; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic wait_pulse(input bit dm, input string nm);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(dm ? dm_valid : if_valid) && n < 40);
        chk(nm, 32'(dm ? dm_valid : if_valid), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_mem_req"}, 32'(mem_bus.mem_req), 32'd0);
        chk({nm, "_mem_we"}, 32'(mem_bus.mem_we), 32'd0);
        chk({nm, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
        chk({nm, "_mem_f3"}, 32'(mem_bus.mem_funct3), 32'd0);
        chk({nm, "_valids"}, 32'({if_valid, dm_valid}), 32'd0);
        chk({nm, "_if_rdata"}, if_rdata, 32'd0);
        chk({nm, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_funct3 = 3'b010;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: fetch only, single-cycle memory
        if_addr = 32'h10; if_req = 1'b1;
        push(1'b0, 32'h0050_0093);
        #1 chk("t1_stall_if_N", 32'(stall_if), 32'd1);
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_bus.mem_req), 32'd1);
        chk("t1_mem_addr", mem_bus.mem_addr, 32'h10);
        chk("t1_mem_we", 32'(mem_bus.mem_we), 32'd0);
        chk("t1_mem_f3", 32'(mem_bus.mem_funct3), 32'd2);
        chk("t1_stall_if_N1", 32'(stall_if), 32'd1);
        chk("t1_no_early_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("t1_if_valid_N2", 32'(if_valid), 32'd1);
        chk("t1_stall_if_N2", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_valid_one_cycle", 32'(if_valid), 32'd0);
        chk("t1_idle_mem_req", 32'(mem_bus.mem_req), 32'd0);

        // 2: collision, DM wins first
        if_addr = 32'h14; if_req = 1'b1;
        dm_addr = 32'h100; dm_we = 1'b0; dm_funct3 = 3'b010; dm_req = 1'b1;
        push(1'b1, 32'h1234_5678);
        push(1'b0, 32'h00A0_0113);
        #1 chk("t2_stall_dm", 32'(stall_dm), 32'd1);
        wait_pulse(1'b1, "t2_dm_pulse");
        chk("t2_stall_if_at_dm", 32'(stall_if), 32'd1);
        dm_req = 1'b0;
        @(negedge clk);
        chk("t2_stall_if_after", 32'(stall_if), 32'd1);
        wait_pulse(1'b0, "t2_if_pulse");
        if_req = 1'b0;
        @(negedge clk);

        // 3: starvation guard, IF wins the 5th arbitration and the counter restarts
        if_addr = 32'h20; if_req = 1'b1;
        dm_addr = 32'h300; dm_req = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, {16'h0300 + 16'(4 * k), 16'hC0DE});
        push(1'b0, 32'h0020_C0DE);
        push(1'b1, 32'h0310_C0DE);
        push(1'b0, 32'h0024_C0DE);
        for (int k = 0; k < 4; k++) begin
            wait_pulse(1'b1, "t3_dm_pulse");
            dm_addr = 32'h304 + 32'(4 * k);
        end
        wait_pulse(1'b0, "t3_if_forced");
        if_addr = 32'h24;
        wait_pulse(1'b1, "t3_dm_after_clear");
        dm_req = 1'b0;
        wait_pulse(1'b0, "t3_if_second");
        if_req = 1'b0;
        @(negedge clk);

        // 4: store with 3-cycle memory; dm_rdata keeps the last load value
        lat = 3;
        dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b000; dm_req = 1'b1;
        push(1'b1, 32'h0310_C0DE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_mem_req", 32'(mem_bus.mem_req), 32'd1);
            chk("t4_mem_we", 32'(mem_bus.mem_we), 32'd1);
            chk("t4_mem_addr", mem_bus.mem_addr, 32'h200);
            chk("t4_mem_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t4_mem_f3", 32'(mem_bus.mem_funct3), 32'd0);
            chk("t4_no_early_valid", 32'(dm_valid), 32'd0);
        end
        wait_pulse(1'b1, "t4_dm_pulse");
        dm_req = 1'b0; dm_we = 1'b0; dm_funct3 = 3'b010;
        @(negedge clk);
        chk("t4_valid_one_cycle", 32'(dm_valid), 32'd0);

        // 5: reset in the middle of a DM load, then stray mem_ready in IDLE (6)
        lat = 5;
        dm_addr = 32'h400; dm_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_busy_mem_req", 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        chk_zero_outputs("t5_after_reset");
        reset = 1'b0; spur = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_spur_mem_req", 32'(mem_bus.mem_req), 32'd0);
            chk("t6_spur_valids", 32'({if_valid, dm_valid}), 32'd0);
        end
        spur = 1'b0; lat = 1;
        @(negedge clk);
        if_addr = 32'h10; if_req = 1'b1;
        push(1'b0, 32'h0050_0093);
        wait_pulse(1'b0, "t6_if_after_spur");
        if_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
